// File: rtl/div_pkg.sv
// Shared definitions for the arithmetic unit's sequential divider.
package div_pkg;

  // State encoding is shared with the shift-add multiplier; IDLE doubles as 'done'.
  typedef enum logic {
    RUN  = 1'b0,
    IDLE = 1'b1
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {R,Q} left, trial-subtract D, keep or restore.
// Purely combinational so it can be replicated for an unrolled or pipelined divider.
module div_step #(
  parameter int W = 4
) (
  input  logic [W-1:0] r_i,
  input  logic [W-1:0] q_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] r_o,
  output logic [W-1:0] q_o
);

  // The bit shifted out of R is kept so divisors up to 2^W-1 never overflow.
  logic [W:0] r_shift;
  logic [W:0] trial;

  // Shift, trial subtract, then select the restored or the reduced remainder.
  always_comb begin
    r_shift = {r_i, q_i[W-1]};
    trial   = r_shift - {1'b0, d_i};
    if (!trial[W]) begin
      // r_shift < 2*D here, so the difference always fits in W bits.
      r_o = trial[W-1:0];
      q_o = {q_i[W-2:0], 1'b1};
    end else begin
      r_o = r_shift[W-1:0];
      q_o = {q_i[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div.sv
// Sequential unsigned restoring divider producing one quotient bit per clock.
// Handshake: start is accepted on a rising edge only while done=1; done=0 means busy.
module div
  import div_pkg::*;
#(
  parameter int N_BITS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N_BITS-1:0] n,
  input  logic [N_BITS-1:0] d,
  output logic [N_BITS-1:0] q,
  output logic [N_BITS-1:0] r,
  output logic              done,
  output logic              dbz
);

  localparam int CW = $clog2(N_BITS + 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q,   cnt_d;
  logic [N_BITS-1:0]  rw_q,    rw_d;    // working remainder R
  logic [N_BITS-1:0]  qw_q,    qw_d;    // working quotient Q (starts as dividend)
  logic [N_BITS-1:0]  dv_q,    dv_d;    // latched divisor D
  logic [N_BITS-1:0]  q_q,     q_d;
  logic [N_BITS-1:0]  r_q,     r_d;
  logic               dbz_q,   dbz_d;
  logic [N_BITS-1:0]  step_r,  step_q;

  div_step #(.W(N_BITS)) u_step (
    .r_i (rw_q),
    .q_i (qw_q),
    .d_i (dv_q),
    .r_o (step_r),
    .q_o (step_q)
  );

  // Next-state and next-data: accept/reject in IDLE, one step per cycle in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    qw_d    = qw_q;
    dv_d    = dv_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (d != '0) begin
            dv_d    = d;
            rw_d    = '0;
            qw_d    = n;
            cnt_d   = CW'(N_BITS);
            q_d     = '0;
            r_d     = '0;
            dbz_d   = 1'b0;
            state_d = RUN;
          end else begin
            // Divide by zero resolves immediately without leaving IDLE.
            q_d   = '1;
            r_d   = n;
            dbz_d = 1'b1;
          end
        end
      end
      RUN: begin
        rw_d  = step_r;
        qw_d  = step_q;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          q_d     = step_q;
          r_d     = step_r;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and data registers; async reset discards any division in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rw_q    <= '0;
      qw_q    <= '0;
      dv_q    <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      qw_q    <= qw_d;
      dv_q    <= dv_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
    end
  end

  assign done = (state_q == IDLE);
  assign q    = q_q;
  assign r    = r_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_div.sv
// Bench for the sequential divider: directed cases, reset, ignored start,
// a held-start exhaustive sweep and random pulsed operations.
module tb_div;

  localparam int N  = 4;
  localparam int EW = 2 * N + 1;        // packed {q, r, dbz}
  localparam logic [N-1:0] ALL1 = '1;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] n_in;
  logic [N-1:0] d_in;
  logic [N-1:0] q;
  logic [N-1:0] r;
  logic         done;
  logic         dbz;

  logic [EW-1:0] exp_q[$];
  int n_checks;
  int n_fail;

  div #(.N_BITS(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .n     (n_in),
    .d     (d_in),
    .q     (q),
    .r     (r),
    .done  (done),
    .dbz   (dbz)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Comparison point shared by every check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, with the divide-by-zero convention
  function automatic logic [EW-1:0] model(input int a, input int b);
    logic [N-1:0] qa;
    logic [N-1:0] ra;
    if (b == 0) return {ALL1, a[N-1:0], 1'b1};
    qa = N'(a / b);
    ra = N'(a % b);
    return {qa, ra, 1'b0};
  endfunction

  // Issue one division from a negedge with done=1; returns at a negedge with done=1.
  // pulse=1 drops start after the accepting edge, pulse=0 leaves it held.
  task automatic run_op(input int a, input int b, input bit pulse, input string tag);
    int low;
    logic [EW-1:0] e;
    start = 1'b1;
    n_in  = N'(a);
    d_in  = N'(b);
    exp_q.push_back(model(a, b));
    @(posedge clk);
    @(negedge clk);
    if (pulse) start = 1'b0;
    if (pulse && b != 0) begin
      check({tag, "_clr_q"}, 32'(q), 32'd0);
      check({tag, "_clr_r"}, 32'(r), 32'd0);
    end
    low = 0;
    while (!done && low < 40) begin
      low++;
      @(negedge clk);
    end
    check({tag, "_done_low"}, low, (b == 0) ? 0 : N);
    e = exp_q.pop_front();
    check({tag, "_q"},   32'(q),   32'(e[EW-1 -: N]));
    check({tag, "_r"},   32'(r),   32'(e[N:1]));
    check({tag, "_dbz"}, 32'(dbz), 32'(e[0]));
  endtask

  // Wait for done with a bound, counting a timeout as a failure
  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while (!done && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    n_in     = '0;
    d_in     = '0;

    // Reset state
    #12;
    check("rst_done", 32'(done), 32'd1);
    check("rst_q",    32'(q),    32'd0);
    check("rst_r",    32'(r),    32'd0);
    check("rst_dbz",  32'(dbz),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_op(13, 4, 1'b1, "d13_4");
    run_op(15, 1, 1'b1, "d15_1");
    run_op(3, 7, 1'b1, "d3_7");
    run_op(15, 15, 1'b1, "d15_15");
    run_op(9, 0, 1'b1, "d9_0");
    run_op(9, 3, 1'b1, "d9_3");

    // Result holds while idle
    repeat (3) @(negedge clk);
    check("hold_q", 32'(q), 32'd3);
    check("hold_r", 32'(r), 32'd0);

    // Start during RUN is ignored and new operands have no effect
    start = 1'b1; n_in = 4'd13; d_in = 4'd4;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; n_in = 4'd6; d_in = 4'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done("ign");
    check("ign_q",   32'(q),   32'd3);
    check("ign_r",   32'(r),   32'd1);
    check("ign_dbz", 32'(dbz), 32'd0);

    // Async reset mid-division
    start = 1'b1; n_in = 4'd13; d_in = 4'd4;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_done", 32'(done), 32'd1);
    check("arst_q",    32'(q),    32'd0);
    check("arst_r",    32'(r),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_idle_q", 32'(q), 32'd0);
    run_op(7, 2, 1'b1, "post_rst");

    // Exhaustive sweep with start held high
    for (int a = 0; a < (1 << N); a++) begin
      for (int b = 0; b < (1 << N); b++) begin
        run_op(a, b, 1'b0, "sweep");
      end
    end
    start = 1'b0;
    @(negedge clk);

    // Random pulsed operations with idle gaps
    for (int i = 0; i < 40; i++) begin
      int a;
      int b;
      a = int'($urandom_range(0, (1 << N) - 1));
      b = int'($urandom_range(0, (1 << N) - 1));
      run_op(a, b, 1'b1, "rand");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
